// File: rtl/mpeg_video_pkg.sv
// Shared types and constants for the MPEG-1 video header parser.
package mpeg_video_pkg;

  // Parser states. The scanner owns SCAN_Z0..CODE; the top owns the header states.
  typedef enum logic [2:0] {
    SCAN_Z0 = 3'd0,
    SCAN_Z1 = 3'd1,
    SCAN_ZN = 3'd2,
    CODE    = 3'd3,
    SEQ     = 3'd4,
    GOP     = 3'd5,
    PIC     = 3'd6
  } state_t;

  // Start-code values (byte following 00 00 01).
  localparam logic [7:0] SC_SEQ_HDR   = 8'hB3;
  localparam logic [7:0] SC_GOP       = 8'hB8;
  localparam logic [7:0] SC_PIC       = 8'h00;
  localparam logic [7:0] SC_SEQ_END   = 8'hB7;
  localparam logic [7:0] SC_SLICE_MIN = 8'h01;
  localparam logic [7:0] SC_SLICE_MAX = 8'hAF;

  // Header payload lengths in bytes.
  localparam logic [2:0] SEQ_LEN = 3'd7;
  localparam logic [2:0] GOP_LEN = 3'd4;
  localparam logic [2:0] PIC_LEN = 3'd4;

  // True for slice start codes 01..AF.
  function automatic logic is_slice_code(input logic [7:0] c);
    return (c >= SC_SLICE_MIN) && (c <= SC_SLICE_MAX);
  endfunction

  // True when idx addresses the final byte of a header of length len.
  function automatic logic is_last_byte(input logic [2:0] idx, input logic [2:0] len);
    return idx == (len - 3'd1);
  endfunction

endpackage

// File: rtl/mpeg_video_header_parser_scanner.sv
// Zero-run / 01 start-code detector. Emits code_valid with the code byte
// on the byte that follows 00 00 01 (any zero run of two or more).
module mpeg_start_code_scanner
  import mpeg_video_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       hold,
  output logic       code_valid,
  output logic [7:0] code
);

  state_t scan_state;
  state_t scan_next;

  // Scanner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_state <= SCAN_Z0;
    end else begin
      scan_state <= scan_next;
    end
  end

  // Advance on valid bytes only while the top is not inside a header.
  always_comb begin
    scan_next  = scan_state;
    code_valid = 1'b0;
    code       = data;
    if (data_valid && !hold) begin
      case (scan_state)
        SCAN_Z0: scan_next = (data == 8'h00) ? SCAN_Z1 : SCAN_Z0;
        SCAN_Z1: scan_next = (data == 8'h00) ? SCAN_ZN : SCAN_Z0;
        SCAN_ZN: begin
          if (data == 8'h00) begin
            scan_next = SCAN_ZN;
          end else if (data == 8'h01) begin
            scan_next = CODE;
          end else begin
            scan_next = SCAN_Z0;
          end
        end
        CODE: begin
          code_valid = 1'b1;
          scan_next  = SCAN_Z0;
        end
        default: scan_next = SCAN_Z0;
      endcase
    end else begin
      scan_next = scan_state;
    end
  end

endmodule

// File: rtl/mpeg_video_header_parser.sv
// Byte-serial MPEG-1 video header parser: sequence, GOP and picture header
// field extraction, slice / sequence-end flags and temporal-reference ordering.
module mpeg_video_header_parser
  import mpeg_video_pkg::*;
#(
  parameter int TMPREF_W     = 16,
  parameter int TMPREF_SHIFT = 2,
  parameter bit SLICE_EVENTS = 1'b1,
  parameter int GOP_CNT_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           mpeg_data,
  input  logic                 data_valid,
  output logic                 event_sequence_header,
  output logic                 event_sequence_end,
  output logic                 event_group_of_pictures,
  output logic                 event_picture,
  output logic                 event_slice,
  output logic [7:0]           slice_row,
  output logic [11:0]          horizontal_size,
  output logic [11:0]          vertical_size,
  output logic [3:0]           aspect_code,
  output logic [3:0]           rate_code,
  output logic [17:0]          bit_rate,
  output logic [23:0]          timecode,
  output logic                 gop_closed,
  output logic                 gop_broken,
  output logic [GOP_CNT_W-1:0] gop_count,
  output logic [9:0]           picture_tref,
  output logic [2:0]           coding_type,
  output logic [15:0]          vbv_delay,
  output logic                 picture_in_order,
  output logic [TMPREF_W-1:0]  tmpref
);

  // SCAN_Z0 here means "scanner owns the stream"; SEQ/GOP/PIC mean header payload.
  state_t              state;
  state_t              state_nxt;
  logic [2:0]          idx;
  logic [2:0]          idx_nxt;
  logic                code_valid;
  logic [7:0]          code;
  logic                hold;
  logic                seq_done;
  logic                gop_done;
  logic                pic_done;
  logic [7:0]          hdr_b [0:5];
  logic [9:0]          exp_tref;
  logic [9:0]          pic_tref;
  logic [TMPREF_W-1:0] pic_tmpref;

  assign hold = (state != SCAN_Z0);

  mpeg_start_code_scanner u_scanner (
    .clk        (clk),
    .reset      (reset),
    .data       (mpeg_data),
    .data_valid (data_valid),
    .hold       (hold),
    .code_valid (code_valid),
    .code       (code)
  );

  // Header FSM state and byte-index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN_Z0;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Header FSM next-state: enter a header on its code, leave on its last byte.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    seq_done  = 1'b0;
    gop_done  = 1'b0;
    pic_done  = 1'b0;
    case (state)
      SCAN_Z0: begin
        idx_nxt = 3'd0;
        if (code_valid) begin
          case (code)
            SC_SEQ_HDR: state_nxt = SEQ;
            SC_GOP:     state_nxt = GOP;
            SC_PIC:     state_nxt = PIC;
            default:    state_nxt = SCAN_Z0;
          endcase
        end else begin
          state_nxt = SCAN_Z0;
        end
      end
      SEQ: begin
        if (data_valid) begin
          if (is_last_byte(idx, SEQ_LEN)) begin
            seq_done  = 1'b1;
            state_nxt = SCAN_Z0;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          idx_nxt = idx;
        end
      end
      GOP: begin
        if (data_valid) begin
          if (is_last_byte(idx, GOP_LEN)) begin
            gop_done  = 1'b1;
            state_nxt = SCAN_Z0;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          idx_nxt = idx;
        end
      end
      PIC: begin
        if (data_valid) begin
          if (is_last_byte(idx, PIC_LEN)) begin
            pic_done  = 1'b1;
            state_nxt = SCAN_Z0;
            idx_nxt   = 3'd0;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          idx_nxt = idx;
        end
      end
      default: begin
        state_nxt = SCAN_Z0;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  // Picture temporal reference and its shifted form for the ordering check.
  always_comb begin
    pic_tref   = {hdr_b[0], hdr_b[1][7:6]};
    pic_tmpref = TMPREF_W'(pic_tref) << TMPREF_SHIFT;
  end

  // Shadow capture of header bytes and atomic output update on header completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        hdr_b[i] <= 8'h00;
      end
      event_sequence_header   <= 1'b0;
      event_sequence_end      <= 1'b0;
      event_group_of_pictures <= 1'b0;
      event_picture           <= 1'b0;
      event_slice             <= 1'b0;
      slice_row               <= 8'h00;
      horizontal_size         <= 12'h000;
      vertical_size           <= 12'h000;
      aspect_code             <= 4'h0;
      rate_code               <= 4'h0;
      bit_rate                <= 18'h00000;
      timecode                <= 24'h000000;
      gop_closed              <= 1'b0;
      gop_broken              <= 1'b0;
      gop_count               <= '0;
      picture_tref            <= 10'h000;
      coding_type             <= 3'h0;
      vbv_delay               <= 16'h0000;
      picture_in_order        <= 1'b0;
      tmpref                  <= '0;
      exp_tref                <= 10'h000;
    end else begin
      event_sequence_header   <= 1'b0;
      event_sequence_end      <= 1'b0;
      event_group_of_pictures <= 1'b0;
      event_picture           <= 1'b0;
      event_slice             <= 1'b0;

      // The final byte of each header is used directly, so it is never shadowed.
      if (hold && data_valid) begin
        for (int i = 0; i < 6; i++) begin
          if (idx == 3'(i)) begin
            hdr_b[i] <= mpeg_data;
          end
        end
      end

      if (code_valid && (code == SC_SEQ_END)) begin
        event_sequence_end <= 1'b1;
      end
      if (SLICE_EVENTS && code_valid && is_slice_code(code)) begin
        event_slice <= 1'b1;
        slice_row   <= code;
      end

      if (seq_done) begin
        event_sequence_header <= 1'b1;
        horizontal_size       <= {hdr_b[0], hdr_b[1][7:4]};
        vertical_size         <= {hdr_b[1][3:0], hdr_b[2]};
        aspect_code           <= hdr_b[3][7:4];
        rate_code             <= hdr_b[3][3:0];
        bit_rate              <= {hdr_b[4], hdr_b[5], mpeg_data[7:6]};
      end

      if (gop_done) begin
        event_group_of_pictures <= 1'b1;
        // Marker bit hdr_b[1][3] is dropped from the packed timecode.
        timecode   <= {hdr_b[0], hdr_b[1][7:4], hdr_b[1][2:0], hdr_b[2], mpeg_data[7]};
        gop_closed <= mpeg_data[6];
        gop_broken <= mpeg_data[5];
        gop_count  <= gop_count + GOP_CNT_W'(1);
        exp_tref   <= 10'h000;
      end

      if (pic_done) begin
        event_picture <= 1'b1;
        picture_tref  <= pic_tref;
        coding_type   <= hdr_b[1][5:3];
        vbv_delay     <= {hdr_b[1][2:0], hdr_b[2], mpeg_data[7:3]};
        if (pic_tref == exp_tref) begin
          picture_in_order <= 1'b1;
          tmpref           <= pic_tmpref;
          exp_tref         <= exp_tref + 10'd1;
        end else begin
          picture_in_order <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpeg_video_header_parser.sv
// Self-checking bench for mpeg_video_header_parser: directed header streams
// followed by random packet streams, compared every cycle against a
// byte-window / header-queue reference model.
module tb_mpeg_video_header_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  mpeg_data;
  logic        data_valid;

  logic        ev_seq, ev_end, ev_gop, ev_pic, ev_slice;
  logic [7:0]  slice_row;
  logic [11:0] hsize, vsize;
  logic [3:0]  aspect, rate;
  logic [17:0] brate;
  logic [23:0] tc;
  logic        closed, broken;
  logic [9:0]  gcnt;
  logic [9:0]  tref;
  logic [2:0]  ctype;
  logic [15:0] vbv;
  logic        inord;
  logic [15:0] tmpref;

  logic        n_ev_seq, n_ev_end, n_ev_gop, n_ev_pic, n_ev_slice;
  logic [7:0]  n_slice_row;
  logic [11:0] n_hsize, n_vsize;
  logic [3:0]  n_aspect, n_rate;
  logic [17:0] n_brate;
  logic [23:0] n_tc;
  logic        n_closed, n_broken;
  logic [9:0]  n_gcnt;
  logic [9:0]  n_tref;
  logic [2:0]  n_ctype;
  logic [15:0] n_vbv;
  logic        n_inord;
  logic [15:0] n_tmpref;

  mpeg_video_header_parser u_dut (
    .clk(clk), .reset(reset), .mpeg_data(mpeg_data), .data_valid(data_valid),
    .event_sequence_header(ev_seq), .event_sequence_end(ev_end),
    .event_group_of_pictures(ev_gop), .event_picture(ev_pic), .event_slice(ev_slice),
    .slice_row(slice_row), .horizontal_size(hsize), .vertical_size(vsize),
    .aspect_code(aspect), .rate_code(rate), .bit_rate(brate), .timecode(tc),
    .gop_closed(closed), .gop_broken(broken), .gop_count(gcnt),
    .picture_tref(tref), .coding_type(ctype), .vbv_delay(vbv),
    .picture_in_order(inord), .tmpref(tmpref)
  );

  mpeg_video_header_parser #(.SLICE_EVENTS(1'b0)) u_dut_noslice (
    .clk(clk), .reset(reset), .mpeg_data(mpeg_data), .data_valid(data_valid),
    .event_sequence_header(n_ev_seq), .event_sequence_end(n_ev_end),
    .event_group_of_pictures(n_ev_gop), .event_picture(n_ev_pic), .event_slice(n_ev_slice),
    .slice_row(n_slice_row), .horizontal_size(n_hsize), .vertical_size(n_vsize),
    .aspect_code(n_aspect), .rate_code(n_rate), .bit_rate(n_brate), .timecode(n_tc),
    .gop_closed(n_closed), .gop_broken(n_broken), .gop_count(n_gcnt),
    .picture_tref(n_tref), .coding_type(n_ctype), .vbv_delay(n_vbv),
    .picture_in_order(n_inord), .tmpref(n_tmpref)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int gap_on = 0;

  // Reference model state
  logic [7:0] win[$];
  logic [7:0] hq[$];
  int m_need, m_kind, m_code_next, m_exp;
  int e_seqh, e_send, e_gop, e_pic, e_slice, e_row;
  int e_hsize, e_vsize, e_aspect, e_rate, e_brate;
  int e_tc, e_closed, e_broken, e_gcnt;
  int e_tref, e_type, e_vbv, e_inord, e_tmpref;

  logic [7:0] seq_bytes [0:10] = '{8'h00,8'h00,8'h01,8'hB3,8'h16,8'h00,8'hF0,8'hC4,8'h02,8'hCE,8'hFF};
  logic [7:0] seq2_bytes[0:10] = '{8'h00,8'h00,8'h01,8'hB3,8'h2D,8'h01,8'hE0,8'h83,8'hFF,8'hFF,8'hC0};
  logic [7:0] gop_bytes [0:9]  = '{8'h00,8'h00,8'h00,8'h00,8'h01,8'hB8,8'h00,8'h18,8'h41,8'hC0};
  logic [7:0] pic5_bytes[0:7]  = '{8'h00,8'h00,8'h01,8'h00,8'h01,8'h48,8'hFF,8'hFF};
  logic [7:0] pic0_bytes[0:7]  = '{8'h00,8'h00,8'h01,8'h00,8'h00,8'h08,8'h00,8'h00};
  logic [7:0] pic1_bytes[0:7]  = '{8'h00,8'h00,8'h01,8'h00,8'h00,8'h48,8'h00,8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete(); hq.delete();
    m_need = 0; m_kind = 0; m_code_next = 0; m_exp = 0;
    e_seqh = 0; e_send = 0; e_gop = 0; e_pic = 0; e_slice = 0; e_row = 0;
    e_hsize = 0; e_vsize = 0; e_aspect = 0; e_rate = 0; e_brate = 0;
    e_tc = 0; e_closed = 0; e_broken = 0; e_gcnt = 0;
    e_tref = 0; e_type = 0; e_vbv = 0; e_inord = 0; e_tmpref = 0;
  endtask

  task automatic decode_hdr();
    int drop, hrs, mins, secs, pict;
    if (m_kind == 'hB3) begin
      e_seqh   = 1;
      e_hsize  = hq[0] * 16 + hq[1] / 16;
      e_vsize  = (hq[1] % 16) * 256 + hq[2];
      e_aspect = hq[3] / 16;
      e_rate   = hq[3] % 16;
      e_brate  = hq[4] * 1024 + hq[5] * 4 + hq[6] / 64;
    end else if (m_kind == 'hB8) begin
      e_gop    = 1;
      drop     = hq[0] / 128;
      hrs      = (hq[0] / 4) % 32;
      mins     = (hq[0] % 4) * 16 + hq[1] / 16;
      secs     = (hq[1] % 8) * 8 + hq[2] / 32;
      pict     = (hq[2] % 32) * 2 + hq[3] / 128;
      e_tc     = drop * (1 << 23) + hrs * (1 << 18) + mins * (1 << 12) + secs * 64 + pict;
      e_closed = (hq[3] / 64) % 2;
      e_broken = (hq[3] / 32) % 2;
      e_gcnt   = (e_gcnt + 1) % 1024;
      m_exp    = 0;
    end else begin
      e_pic  = 1;
      e_tref = hq[0] * 4 + hq[1] / 64;
      e_type = (hq[1] / 8) % 8;
      e_vbv  = (hq[1] % 8) * 8192 + hq[2] * 32 + hq[3] / 8;
      if (e_tref == m_exp) begin
        e_inord  = 1;
        e_tmpref = e_tref * 4;
        m_exp    = (m_exp + 1) % 1024;
      end else begin
        e_inord = 0;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] b, input bit v);
    e_seqh = 0; e_send = 0; e_gop = 0; e_pic = 0; e_slice = 0;
    if (v) begin
      if (m_need > 0) begin
        hq.push_back(b);
        if (hq.size() == m_need) begin
          decode_hdr();
          m_need = 0;
          hq.delete();
        end
      end else if (m_code_next != 0) begin
        m_code_next = 0;
        m_kind = b;
        if (b == 8'hB3) m_need = 7;
        else if (b == 8'hB8 || b == 8'h00) m_need = 4;
        else if (b == 8'hB7) e_send = 1;
        else if (b >= 8'h01 && b <= 8'hAF) begin
          e_slice = 1;
          e_row   = b;
        end
      end else begin
        win.push_back(b);
        if (win.size() > 3) void'(win.pop_front());
        if (win.size() == 3 && win[0] == 8'h00 && win[1] == 8'h00 && win[2] == 8'h01) begin
          m_code_next = 1;
          win.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    chk("ev_seq", ev_seq, e_seqh);
    chk("ev_end", ev_end, e_send);
    chk("ev_gop", ev_gop, e_gop);
    chk("ev_pic", ev_pic, e_pic);
    chk("ev_slice", ev_slice, e_slice);
    chk("slice_row", slice_row, e_row);
    chk("hsize", hsize, e_hsize);
    chk("vsize", vsize, e_vsize);
    chk("aspect", aspect, e_aspect);
    chk("rate", rate, e_rate);
    chk("bit_rate", brate, e_brate);
    chk("timecode", tc, e_tc);
    chk("closed", closed, e_closed);
    chk("broken", broken, e_broken);
    chk("gop_count", gcnt, e_gcnt);
    chk("tref", tref, e_tref);
    chk("ctype", ctype, e_type);
    chk("vbv", vbv, e_vbv);
    chk("in_order", inord, e_inord);
    chk("tmpref", tmpref, e_tmpref);
    chk("ns_ev_slice", n_ev_slice, 0);
    chk("ns_slice_row", n_slice_row, 0);
    chk("ns_ev_seq", n_ev_seq, e_seqh);
    chk("ns_ev_end", n_ev_end, e_send);
    chk("ns_ev_pic", n_ev_pic, e_pic);
    chk("ns_tmpref", n_tmpref, e_tmpref);
  endtask

  task automatic cycle(input logic [7:0] b, input bit v, input bit r);
    mpeg_data  = b;
    data_valid = v;
    reset      = r;
    if (r) model_reset();
    else   model_step(b, v);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    if (gap_on != 0) begin
      while ($urandom_range(0, 3) == 0) cycle(8'($urandom), 1'b0, 1'b0);
    end
    cycle(b, 1'b1, 1'b0);
  endtask

  initial begin
    int kind, t, n;
    reset      = 1'b1;
    mpeg_data  = 8'h00;
    data_valid = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset held with valid data
    cycle(8'h00, 1'b1, 1'b1); cycle(8'h00, 1'b1, 1'b1);
    cycle(8'h01, 1'b1, 1'b1); cycle(8'hB3, 1'b1, 1'b1);
    chk("rst_hsize", hsize, 0);
    chk("rst_gcnt", gcnt, 0);

    // Reset on the code byte: following payload must not form a header
    cycle(8'h00, 1'b1, 1'b0); cycle(8'h00, 1'b1, 1'b0);
    cycle(8'h01, 1'b1, 1'b0); cycle(8'hB3, 1'b1, 1'b1);
    for (int i = 4; i < 11; i++) send(seq_bytes[i]);
    chk("rstcode_no_ev", ev_seq, 0);
    chk("rstcode_hsize", hsize, 0);

    // Sequence header
    foreach (seq_bytes[i]) send(seq_bytes[i]);
    chk("seq_ev", ev_seq, 1);
    chk("seq_hsize", hsize, 352);
    chk("seq_vsize", vsize, 240);
    chk("seq_aspect", aspect, 12);
    chk("seq_rate", rate, 4);
    chk("seq_brate", brate, 2875);

    // GOP with three leading zeros
    foreach (gop_bytes[i]) send(gop_bytes[i]);
    chk("gop_ev", ev_gop, 1);
    chk("gop_tc", tc, 24'h001083);
    chk("gop_closed", closed, 1);
    chk("gop_broken", broken, 0);
    chk("gop_cnt", gcnt, 1);

    // Picture ordering
    foreach (pic5_bytes[i]) send(pic5_bytes[i]);
    chk("pic5_tref", tref, 5);
    chk("pic5_type", ctype, 1);
    chk("pic5_vbv", vbv, 16'h1FFF);
    chk("pic5_inord", inord, 0);
    chk("pic5_tmpref", tmpref, 0);
    foreach (pic0_bytes[i]) send(pic0_bytes[i]);
    chk("pic0_inord", inord, 1);
    chk("pic0_tmpref", tmpref, 0);
    foreach (pic1_bytes[i]) send(pic1_bytes[i]);
    chk("pic1_inord", inord, 1);
    chk("pic1_tmpref", tmpref, 4);

    // Slice, sequence end, unknown code
    send(8'h00); send(8'h00); send(8'h01); send(8'h01);
    chk("slice_ev", ev_slice, 1);
    chk("slice_row01", slice_row, 1);
    chk("noslice_ev", n_ev_slice, 0);
    send(8'h00); send(8'h00); send(8'h01); send(8'hB7);
    chk("seqend_ev", ev_end, 1);
    send(8'h00); send(8'h00); send(8'h01); send(8'hB2);
    chk("b2_no_end", ev_end, 0);
    chk("b2_no_slice", ev_slice, 0);
    send(8'h00); send(8'h00); send(8'h01); send(8'hB7);
    chk("b2_rescan", ev_end, 1);

    // data_valid gaps on every other cycle
    foreach (seq2_bytes[i]) send(seq2_bytes[i]);
    chk("seq2_hsize", hsize, 720);
    for (int i = 0; i < 11; i++) begin
      cycle(seq_bytes[i], 1'b1, 1'b0);
      if (i == 10) begin
        chk("gap_pulse", ev_seq, 1);
      end
      cycle(8'h00, 1'b0, 1'b0);
    end
    chk("gap_pulse_end", ev_seq, 0);
    chk("gap_hsize", hsize, 352);
    chk("gap_brate", brate, 2875);

    // Random packet stream
    gap_on = 1;
    for (int p = 0; p < 300; p++) begin
      kind = $urandom_range(0, 8);
      send(8'h00); send(8'h00);
      if ($urandom_range(0, 1) == 1) send(8'h00);
      send(8'h01);
      case (kind)
        0: begin send(8'hB3); for (int i = 0; i < 7; i++) send(8'($urandom)); end
        1: begin send(8'hB8); for (int i = 0; i < 4; i++) send(8'($urandom)); end
        2, 3: begin
          send(8'h00);
          n = $urandom_range(0, 3);
          t = (n < 3) ? (m_exp + n) % 1024 : $urandom_range(0, 1023);
          send(8'(t / 4));
          send(8'(((t % 4) << 6) | $urandom_range(0, 63)));
          send(8'($urandom)); send(8'($urandom));
        end
        4: send(8'($urandom_range(1, 175)));
        5: send(8'hB7);
        6: send(8'($urandom));
        7: begin
          send(8'hB3); send(8'($urandom)); send(8'($urandom));
          cycle(8'($urandom), 1'b1, 1'b1);
        end
        default: for (int i = 0; i < 3; i++) send(8'($urandom));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpeg_video_header_parser.md
Name: mpeg_video_header_parser

Overview:
Byte-serial MPEG-1 video elementary-stream parser; parametrised successor to the FMV start-code decoder. Scans for 00 00 01 xx start codes. Extracts the full field sets of the sequence, GOP and picture headers, and flags slice and sequence-end codes. Tracks temporal-reference ordering inside each GOP. Sits between the FMV demux byte output and the FMV decoder control / frame scheduler.

Parameters:
TMPREF_W, 16, width of tmpref output
TMPREF_SHIFT, 2, left shift applied to the 10-bit temporal reference when written into tmpref (TMPREF_SHIFT+10 <= TMPREF_W)
SLICE_EVENTS, 1, 1 = emit event_slice for codes 01..AF; 0 = slice codes ignored
GOP_CNT_W, 10, width of gop_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
mpeg_data  in  8  stream byte
data_valid  in  1  byte qualifier; no backpressure
event_sequence_header  out  1  pulse: sequence header fields updated
event_sequence_end  out  1  pulse: start code B7 seen
event_group_of_pictures  out  1  pulse: GOP fields updated
event_picture  out  1  pulse: picture fields updated
event_slice  out  1  pulse: slice start code seen
slice_row  out  8  slice start code value (01..AF)
horizontal_size  out  12  sequence header
vertical_size  out  12  sequence header
aspect_code  out  4  sequence header
rate_code  out  4  sequence header
bit_rate  out  18  sequence header, units of 400 bit/s
timecode  out  24  {drop, hours[4:0], minutes[5:0], seconds[5:0], pictures[5:0]}
gop_closed  out  1  GOP closed_gop
gop_broken  out  1  GOP broken_link
gop_count  out  GOP_CNT_W  GOPs parsed since reset; wraps
picture_tref  out  10  raw temporal reference of last picture
coding_type  out  3  last picture coding type
vbv_delay  out  16  last picture vbv_delay
picture_in_order  out  1  last picture tref equalled expected value
tmpref  out  TMPREF_W  in-order tref << TMPREF_SHIFT

Behaviour:
- Reset: all outputs and internal registers 0; state SCAN_Z0. Reset wins over data_valid in the same cycle.
- data_valid=0: no state change, event outputs 0. Events are single-cycle pulses in the cycle after the final header byte is accepted.
- Start-code FSM (acts only on valid bytes):
  - SCAN_Z0 -(00)-> SCAN_Z1 -(00)-> SCAN_ZN.
  - SCAN_ZN: 00 stays (any zero run >= 2); 01 -> CODE.
  - Any other byte returns to SCAN_Z0.
- CODE, by byte value:
  - B3 -> SEQ.
  - B8 -> GOP.
  - 00 -> PIC.
  - B7 -> pulse event_sequence_end, go to SCAN_Z0.
  - 01..AF with SLICE_EVENTS=1 -> latch slice_row, pulse event_slice, go to SCAN_Z0.
  - Anything else -> SCAN_Z0.
- Header states use a shared 3-bit byte index. Header bytes are consumed unconditionally; no start-code detection inside a header.
- SEQ, 7 bytes:
  - b0 = hsize[11:4]; b1 = {hsize[3:0], vsize[11:8]}; b2 = vsize[7:0]; b3 = {aspect, rate}.
  - b4 = bitrate[17:10]; b5 = bitrate[9:2]; b6[7:6] = bitrate[1:0].
  - Fields go into shadow registers; all outputs update together with the pulse.
- GOP, 4 bytes:
  - b0 = {drop, hours, min[5:4]}; b1 = {min[3:0], marker, sec[5:3]}.
  - b2 = {sec[2:0], pict[5:1]}; b3 = {pict[0], closed, broken, x}.
  - On completion: outputs update, gop_count increments, expected tref reset to 0.
- PIC, 4 bytes:
  - b0 = tref[9:2]; b1 = {tref[1:0], type, vbv[15:13]}; b2 = vbv[12:5]; b3[7:3] = vbv[4:0].
  - On completion, if tref == expected: picture_in_order=1, tmpref = tref << TMPREF_SHIFT (zero-extended), expected += 1 (10-bit wrap).
  - Otherwise: picture_in_order=0; tmpref and expected are unchanged.
- After any header completes, go to SCAN_Z0.
- Reset mid-header discards shadow fields; outputs read 0.

Decomposition:
- Shared package mpeg_video_pkg: state enum, start-code constants (SEQ_HDR=B3, GOP=B8, PIC=00, SEQ_END=B7, SLICE_MIN=01, SLICE_MAX=AF), header byte lengths (7/4/4).
- One sub-module, mpeg_start_code_scanner, holds the zero-run/01 detection. It outputs a code_valid strobe plus the code byte.

Test Plan:
- Reset checks:
  - Reset held with valid data -> all outputs 0.
  - Data 00 00 01 B3 with reset asserted on the B3 cycle -> no event.
- Sequence header: 00 00 01 B3 16 00 F0 C4 02 CE FF -> single event_sequence_header; horizontal_size=352, vertical_size=240, aspect_code=C, rate_code=4, bit_rate=2875.
- GOP header: 00 00 00 00 01 B8 00 18 41 C0 (extra leading zero) -> event_group_of_pictures; timecode = drop0 h0 m1 s2 p3; gop_closed=1; gop_broken=0; gop_count=1.
- Picture ordering:
  - After GOP, picture 00 00 01 00 01 48 FF FF -> picture_tref=5, coding_type=1, vbv_delay=1FFF, picture_in_order=0, tmpref unchanged (0).
  - Then picture tref=0 -> picture_in_order=1, tmpref=0.
  - Then tref=1 -> tmpref=4.
- Slice and sequence end:
  - 00 00 01 01 -> event_slice, slice_row=01.
  - With SLICE_EVENTS=0 -> no pulse.
  - 00 00 01 B7 -> event_sequence_end.
  - 00 00 01 B2 -> no event, back to scanning.
- data_valid gaps: sequence-header stream with data_valid low every other cycle -> identical field values; pulse one cycle after last valid byte.
